// File: rtl/text_buffer_writer_if.sv
// Command handshake between the terminal control logic (master) and the
// text buffer writer (slave).
interface text_buffer_writer_if #(
    parameter int CW = 7
);
    logic          char_valid;
    logic          char_ready;
    logic [1:0]    cmd;
    logic [CW-1:0] char_code;

    modport master (output char_valid, output cmd, output char_code, input char_ready);
    modport slave  (input char_valid, input cmd, input char_code, output char_ready);
endinterface

// File: rtl/text_buffer_writer.sv
// Producer of the packed character bus for the VGA text renderer; edits go to a
// working buffer that is published only at vertical-blank start. Optional macro: CURSOR_BLINK_EN.
module text_buffer_writer #(
    parameter int                LINES       = 12,
    parameter int                CHARS       = 9,
    parameter int                CW          = 7,
    parameter logic [CW-1:0]     BLANK_CHAR  = 7'h20,
    parameter logic [9:0]        VBLANK_LINE = 10'd480
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    text_buffer_writer_if.slave          s_bus,
    input  logic                         i_clear_all,
    input  logic [9:0]                   i_v_counter,
    output logic [LINES*CHARS*CW-1:0]    o_words,
    output logic [3:0]                   o_cursor_line,
    output logic [3:0]                   o_cursor_col,
    output logic                         o_busy
);
    localparam int         CELLS     = LINES * CHARS;
    localparam int         WBITS     = CELLS * CW;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_CLEAR  = 1'b1;
    localparam logic [3:0] LAST_LINE = 4'(LINES - 1);
    localparam logic [3:0] LAST_COL  = 4'(CHARS - 1);
    localparam logic [6:0] LAST_CELL = 7'(CELLS - 1);

    // Cell k = line*CHARS + col; cell 0 sits in the most significant bits.
    function automatic logic [6:0] cell_idx(input logic [3:0] line, input logic [3:0] col);
        return 7'(int'(line) * CHARS + int'(col));
    endfunction

    function automatic logic [9:0] cell_lsb(input logic [6:0] k);
        return 10'((CELLS - 1 - int'(k)) * CW);
    endfunction

    logic [WBITS-1:0] r_buf;
    logic [WBITS-1:0] r_words;
    logic [3:0]       r_line;
    logic [3:0]       r_col;
    logic [0:0]       r_state;
    logic [6:0]       r_clr_idx;
    logic             r_dirty;
    logic [9:0]       r_ve_q;

    logic             w_xfer;
    logic             w_clear_done;
    logic             w_vblank_edge;
    logic             w_commit;
    logic [WBITS-1:0] w_publish;
    logic [3:0]       w_line_inc;
    logic [9:0]       w_cur_lsb;

    assign s_bus.char_ready = (r_state == ST_IDLE) & ~i_clear_all;
    assign w_xfer           = s_bus.char_valid & s_bus.char_ready;
    assign w_clear_done     = (r_state == ST_CLEAR) & ~i_clear_all & (r_clr_idx == LAST_CELL);
    assign w_vblank_edge    = (r_ve_q != VBLANK_LINE) & (i_v_counter == VBLANK_LINE);
    assign w_line_inc       = (r_line == LAST_LINE) ? 4'd0 : r_line + 4'd1;
    assign w_cur_lsb        = cell_lsb(cell_idx(r_line, r_col));

`ifdef CURSOR_BLINK_EN
    logic [5:0] r_frame;
    logic       r_shown_blink;
    logic [5:0] w_frame_next;

    assign w_frame_next = w_vblank_edge ? r_frame + 6'd1 : r_frame;
    // A change of blink phase forces a publish even with no pending edits.
    assign w_commit     = w_vblank_edge & (r_state == ST_IDLE) &
                          (r_dirty | (w_frame_next[5] != r_shown_blink));

    // Published image: working buffer with the cursor cell overlaid in the on-phase.
    always_comb begin
        w_publish = r_buf;
        if (w_frame_next[5]) begin
            w_publish[w_cur_lsb +: CW] = 7'h5F;
        end else begin
            w_publish[w_cur_lsb +: CW] = r_buf[w_cur_lsb +: CW];
        end
    end

    // Frame counter and the blink phase currently on the bus.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame       <= 6'd0;
            r_shown_blink <= 1'b0;
        end else begin
            r_frame <= w_frame_next;
            if (w_commit) begin
                r_shown_blink <= w_frame_next[5];
            end
        end
    end
`else
    assign w_commit  = w_vblank_edge & (r_state == ST_IDLE) & r_dirty;
    assign w_publish = r_buf;
`endif

    // Working buffer, cursor, clear sequencer, dirty flag and publish register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf     <= {CELLS{BLANK_CHAR}};
            r_words   <= {CELLS{BLANK_CHAR}};
            r_line    <= 4'd0;
            r_col     <= 4'd0;
            r_state   <= ST_IDLE;
            r_clr_idx <= 7'd0;
            r_dirty   <= 1'b0;
            r_ve_q    <= 10'd0;
        end else begin
            r_ve_q <= i_v_counter;
            if (w_commit) begin
                r_words <= w_publish;
            end
            // A same-cycle transfer wins over the commit so the new edit is not lost.
            if (w_xfer || w_clear_done) begin
                r_dirty <= 1'b1;
            end else if (w_commit) begin
                r_dirty <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_clear_all) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= 7'd0;
                    end else if (w_xfer) begin
                        case (s_bus.cmd)
                            2'b00: begin
                                r_buf[w_cur_lsb +: CW] <= s_bus.char_code;
                                if (r_col == LAST_COL) begin
                                    r_col  <= 4'd0;
                                    r_line <= w_line_inc;
                                end else begin
                                    r_col <= r_col + 4'd1;
                                end
                            end
                            2'b01: begin
                                if (r_col != 4'd0) begin
                                    r_col <= r_col - 4'd1;
                                    r_buf[cell_lsb(cell_idx(r_line, r_col - 4'd1)) +: CW] <= BLANK_CHAR;
                                end else if (r_line != 4'd0) begin
                                    r_line <= r_line - 4'd1;
                                    r_col  <= LAST_COL;
                                    r_buf[cell_lsb(cell_idx(r_line - 4'd1, LAST_COL)) +: CW] <= BLANK_CHAR;
                                end
                            end
                            2'b10: begin
                                r_col  <= 4'd0;
                                r_line <= w_line_inc;
                            end
                            default: begin
                                for (int c = 0; c < CHARS; c++) begin
                                    r_buf[cell_lsb(cell_idx(r_line, 4'(c))) +: CW] <= BLANK_CHAR;
                                end
                                r_col <= 4'd0;
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    if (i_clear_all) begin
                        r_clr_idx <= 7'd0;
                    end else begin
                        r_buf[cell_lsb(r_clr_idx) +: CW] <= BLANK_CHAR;
                        if (w_clear_done) begin
                            r_state <= ST_IDLE;
                            r_line  <= 4'd0;
                            r_col   <= 4'd0;
                        end else begin
                            r_clr_idx <= r_clr_idx + 7'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_words       = r_words;
    assign o_cursor_line = r_line;
    assign o_cursor_col  = r_col;
    assign o_busy        = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer (default build) with a reference model
// and a scoreboard queue of expected published images.
module tb_text_buffer_writer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear_all = 1'b0;
    logic [9:0]   v_cnt = 10'd0;
    logic [755:0] words;
    logic [3:0]   cur_line;
    logic [3:0]   cur_col;
    logic         busy;

    text_buffer_writer_if #(.CW(7)) bus();

    text_buffer_writer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .s_bus         (bus),
        .i_clear_all   (clear_all),
        .i_v_counter   (v_cnt),
        .o_words       (words),
        .o_cursor_line (cur_line),
        .o_cursor_col  (cur_col),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [6:0]   m_buf [108];
    logic [3:0]   m_line;
    logic [3:0]   m_col;
    logic         m_dirty;
    logic [755:0] m_words;
    logic [755:0] q_exp [$];

    task automatic check(input string tag, input logic [755:0] obs, input logic [755:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [755:0] pack();
        logic [755:0] v;
        for (int k = 0; k < 108; k++) v[(107 - k) * 7 +: 7] = m_buf[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 108; k++) m_buf[k] = 7'h20;
        m_line  = 4'd0;
        m_col   = 4'd0;
        m_dirty = 1'b0;
        m_words = pack();
        q_exp.delete();
    endtask

    function automatic int idx(input logic [3:0] l, input logic [3:0] c);
        return int'(l) * 9 + int'(c);
    endfunction

    task automatic model_apply(input logic [1:0] c, input logic [6:0] code);
        case (c)
            2'b00: begin
                m_buf[idx(m_line, m_col)] = code;
                if (m_col == 4'd8) begin
                    m_col  = 4'd0;
                    m_line = (m_line == 4'd11) ? 4'd0 : m_line + 4'd1;
                end else m_col = m_col + 4'd1;
            end
            2'b01: begin
                if (m_col != 4'd0) begin
                    m_col = m_col - 4'd1;
                    m_buf[idx(m_line, m_col)] = 7'h20;
                end else if (m_line != 4'd0) begin
                    m_line = m_line - 4'd1;
                    m_col  = 4'd8;
                    m_buf[idx(m_line, m_col)] = 7'h20;
                end
            end
            2'b10: begin
                m_col  = 4'd0;
                m_line = (m_line == 4'd11) ? 4'd0 : m_line + 4'd1;
            end
            default: begin
                for (int i = 0; i < 9; i++) m_buf[idx(m_line, 4'(i))] = 7'h20;
                m_col = 4'd0;
            end
        endcase
        m_dirty = 1'b1;
    endtask

    task automatic send(input logic [1:0] c, input logic [6:0] code);
        bus.char_valid = 1'b1;
        bus.cmd        = c;
        bus.char_code  = code;
        tick();
        bus.char_valid = 1'b0;
        model_apply(c, code);
    endtask

    task automatic vblank(input string tag);
        if (m_dirty) begin
            m_words = pack();
            m_dirty = 1'b0;
        end
        q_exp.push_back(m_words);
        v_cnt = 10'd480;
        tick();
        v_cnt = 10'd0;
        tick();
        check(tag, words, q_exp.pop_front());
    endtask

    task automatic check_held(input string tag);
        q_exp.push_back(m_words);
        check(tag, words, q_exp.pop_front());
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_line"}, 756'(cur_line), 756'(m_line));
        check({tag, "_col"},  756'(cur_col),  756'(m_col));
    endtask

    initial begin
        int cnt;
        bus.char_valid = 1'b0;
        bus.cmd        = 2'b00;
        bus.char_code  = 7'h00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();

        // Reset state
        check_held("reset_words");
        check_cursor("reset_cursor");
        check("reset_ready", 756'(bus.char_ready), 756'(1'b1));
        check("reset_busy", 756'(busy), 756'(1'b0));
        vblank("reset_vblank");

        // Two writes, held until vblank
        send(2'b00, 7'h41);
        send(2'b00, 7'h42);
        check_held("ab_before_vblank");
        check_cursor("ab_cursor");
        vblank("ab_vblank");
        check("ab_slice", 756'(words[755:742]), 756'({7'h41, 7'h42}));

        // Fill line 0, wrap, then backspace across the line boundary
        for (int i = 0; i < 7; i++) send(2'b00, 7'(7'h61 + i));
        check_cursor("wrap_cursor");
        send(2'b01, 7'h00);
        check_cursor("bs_line_cursor");
        vblank("bs_line_vblank");
        check("bs_cell_0_8", 756'(words[699:693]), 756'(7'h20));

        // Newline then a write on line 1
        send(2'b10, 7'h00);
        send(2'b00, 7'h58);
        check_cursor("nl_cursor");
        vblank("nl_vblank");
        check("line1_col0", 756'(words[692:686]), 756'(7'h58));

        // Clear current line
        send(2'b11, 7'h00);
        check_cursor("clrline_cursor");
        vblank("clrline_vblank");

        // clear_all with a coincident write request
        clear_all      = 1'b1;
        bus.char_valid = 1'b1;
        bus.cmd        = 2'b00;
        bus.char_code  = 7'h5A;
        #1;
        check("clr_ready_low", 756'(bus.char_ready), 756'(1'b0));
        tick();
        clear_all      = 1'b0;
        bus.char_valid = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            v_cnt = (cnt == 50) ? 10'd480 : 10'd0;
            tick();
            cnt++;
        end
        v_cnt = 10'd0;
        check("clr_busy_cycles", 756'(cnt), 756'(108));
        check_held("clr_no_commit");
        for (int k = 0; k < 108; k++) m_buf[k] = 7'h20;
        m_line  = 4'd0;
        m_col   = 4'd0;
        m_dirty = 1'b1;
        check_cursor("clr_cursor");
        vblank("clr_vblank");

        // Backspace at origin
        send(2'b01, 7'h00);
        check_cursor("bs_origin_cursor");
        vblank("bs_origin_vblank");

        // Full wrap of the buffer
        for (int i = 0; i < 108; i++) send(2'b00, 7'(33 + (i % 90)));
        check_cursor("full_wrap_cursor");
        vblank("full_wrap_vblank");

        // Write coincident with vblank edge
        send(2'b00, 7'h50);
        m_words = pack();
        m_dirty = 1'b0;
        bus.char_valid = 1'b1;
        bus.cmd        = 2'b00;
        bus.char_code  = 7'h51;
        v_cnt          = 10'd480;
        tick();
        bus.char_valid = 1'b0;
        v_cnt          = 10'd0;
        model_apply(2'b00, 7'h51);
        q_exp.push_back(m_words);
        tick();
        check("coincide_words", words, q_exp.pop_front());
        check_cursor("coincide_cursor");
        vblank("coincide_next_vblank");

        // Reset in the middle of a clear
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("midclr_busy", 756'(busy), 756'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("midclr_rst_busy", 756'(busy), 756'(1'b0));
        check_cursor("midclr_rst_cursor");
        check_held("midclr_rst_words");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
